// File: rtl/prog_beam_trigger.sv
// Programmable beamforming trigger: NBEAMS delayed coherent sums of NCHAN channels,
// squared and integrated per clock, thresholded with per-beam holdoff and shadow/active config.
module prog_beam_trigger #(
    parameter  int NCHAN  = 8,
    parameter  int NBITS  = 5,
    parameter  int NSAMP  = 8,
    parameter  int NBEAMS = 4,
    parameter  int DEPTH  = 4,
    localparam int SW     = NBITS + $clog2(NCHAN),
    localparam int PBITS  = 2 * SW + $clog2(NSAMP),
    localparam int BW     = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
    localparam int SELW   = $clog2(NCHAN + 2)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0]   data_i,
    input  logic [BW-1:0]                  cfg_beam_i,
    input  logic [SELW-1:0]                cfg_sel_i,
    input  logic [PBITS-1:0]               cfg_dat_i,
    input  logic                           cfg_wr_i,
    input  logic                           cfg_update_i,
    output logic [NBEAMS-1:0]              trigger_o
);

    localparam int DMAX  = (DEPTH - 1) * NSAMP;
    localparam int DW    = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
    localparam int HW    = 8;
    localparam int SQW   = 2 * SW;
    localparam int SLICE = NSAMP * NBITS;
    localparam int HISTW = DEPTH * SLICE;
    localparam int FLUSH = 5;

    // Per-channel history, oldest sample in the LSBs, newest clock in the top slice
    logic [HISTW-1:0]        hist_q   [NCHAN];
    logic [HISTW-1:0]        hist_d   [NCHAN];

    logic [DW-1:0]           sh_dly_q [NBEAMS][NCHAN];
    logic [DW-1:0]           sh_dly_d [NBEAMS][NCHAN];
    logic [DW-1:0]           act_dly_q[NBEAMS][NCHAN];
    logic [PBITS-1:0]        sh_thr_q [NBEAMS];
    logic [PBITS-1:0]        sh_thr_d [NBEAMS];
    logic [PBITS-1:0]        act_thr_q[NBEAMS];
    logic [HW-1:0]           sh_hold_q[NBEAMS];
    logic [HW-1:0]           sh_hold_d[NBEAMS];
    logic [HW-1:0]           act_hold_q[NBEAMS];

    logic [SLICE-1:0]        win_q    [NBEAMS][NCHAN];
    logic [SLICE-1:0]        win_d    [NBEAMS][NCHAN];
    logic signed [SW-1:0]    sum_q    [NBEAMS][NSAMP];
    logic signed [SW-1:0]    sum_d    [NBEAMS][NSAMP];
    logic [SQW-1:0]          sq_q     [NBEAMS][NSAMP];
    logic [SQW-1:0]          sq_d     [NBEAMS][NSAMP];
    logic [PBITS-1:0]        pwr_q    [NBEAMS];
    logic [PBITS-1:0]        pwr_d    [NBEAMS];
    logic [HW-1:0]           hcnt_q   [NBEAMS];
    logic [HW-1:0]           hcnt_d   [NBEAMS];
    logic [2:0]              flush_q, flush_d;
    logic [NBEAMS-1:0]       trig_q, trig_d;
    logic [DW-1:0]           dly_sat;

    assign dly_sat   = (cfg_dat_i > PBITS'(DMAX)) ? DW'(DMAX) : cfg_dat_i[DW-1:0];
    assign trigger_o = trig_q;

    always_comb begin : cfg_write
        sh_dly_d  = sh_dly_q;
        sh_thr_d  = sh_thr_q;
        sh_hold_d = sh_hold_q;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            if (cfg_wr_i && cfg_beam_i == BW'(b)) begin
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    if (cfg_sel_i == SELW'(c)) sh_dly_d[b][c] = dly_sat;
                end
                if (cfg_sel_i == SELW'(NCHAN))     sh_thr_d[b]  = cfg_dat_i;
                if (cfg_sel_i == SELW'(NCHAN + 1)) sh_hold_d[b] = cfg_dat_i[HW-1:0];
            end
        end
    end

    always_comb begin : store_and_window
        for (int unsigned c = 0; c < NCHAN; c++) begin
            hist_d[c] = HISTW'({data_i[c*SLICE +: SLICE], hist_q[c]} >> SLICE);
        end
        // Delay d picks the window ending d samples before the newest stored sample
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                win_d[b][c] = SLICE'(hist_q[c] >> ((DMAX - int'(act_dly_q[b][c])) * NBITS));
            end
        end
    end

    always_comb begin : arith
        logic signed [SW-1:0]  acc;
        logic signed [SQW-1:0] sext;
        logic [PBITS-1:0]      pacc;
        acc  = '0;
        sext = '0;
        pacc = '0;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            for (int unsigned s = 0; s < NSAMP; s++) begin
                acc = '0;
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    acc = acc + SW'($signed(win_q[b][c][s*NBITS +: NBITS]));
                end
                sum_d[b][s] = acc;
                sext        = SQW'(sum_q[b][s]);
                sq_d[b][s]  = sext * sext;
            end
            pacc = '0;
            for (int unsigned s = 0; s < NSAMP; s++) begin
                pacc = pacc + PBITS'(sq_q[b][s]);
            end
            pwr_d[b] = pacc;
        end
    end

    always_comb begin : fire_ctrl
        trig_d = '0;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            trig_d[b] = (pwr_q[b] > act_thr_q[b]) && (hcnt_q[b] == '0) && (flush_q == '0);
            hcnt_d[b] = hcnt_q[b];
            if (cfg_update_i)          hcnt_d[b] = '0;
            else if (trig_d[b])        hcnt_d[b] = act_hold_q[b];
            else if (hcnt_q[b] != '0)  hcnt_d[b] = hcnt_q[b] - 1'b1;
        end
        flush_d = flush_q;
        if (cfg_update_i)        flush_d = 3'(FLUSH);
        else if (flush_q != '0)  flush_d = flush_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NCHAN; c++) hist_q[c] <= '0;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    sh_dly_q[b][c]  <= '0;
                    act_dly_q[b][c] <= '0;
                    win_q[b][c]     <= '0;
                end
                for (int unsigned s = 0; s < NSAMP; s++) begin
                    sum_q[b][s] <= '0;
                    sq_q[b][s]  <= '0;
                end
                sh_thr_q[b]   <= '1;
                act_thr_q[b]  <= '1;
                sh_hold_q[b]  <= '0;
                act_hold_q[b] <= '0;
                pwr_q[b]      <= '0;
                hcnt_q[b]     <= '0;
            end
            flush_q <= '0;
            trig_q  <= '0;
        end else begin
            hist_q    <= hist_d;
            win_q     <= win_d;
            sum_q     <= sum_d;
            sq_q      <= sq_d;
            pwr_q     <= pwr_d;
            hcnt_q    <= hcnt_d;
            flush_q   <= flush_d;
            trig_q    <= trig_d;
            sh_dly_q  <= sh_dly_d;
            sh_thr_q  <= sh_thr_d;
            sh_hold_q <= sh_hold_d;
            // Active copies take the shadow as it stood before any same-cycle write
            if (cfg_update_i) begin
                act_dly_q  <= sh_dly_q;
                act_thr_q  <= sh_thr_q;
                act_hold_q <= sh_hold_q;
            end
        end
    end

endmodule

// File: tb/tb_prog_beam_trigger.sv
// Scoreboard bench for prog_beam_trigger: expected trigger vectors are queued with their
// due cycle as stimulus is driven, and compared when that cycle's output is sampled.
module tb_prog_beam_trigger;

    localparam int NCHAN  = 8;
    localparam int NBITS  = 5;
    localparam int NSAMP  = 8;
    localparam int NBEAMS = 4;
    localparam int DEPTH  = 4;
    localparam int PBITS  = 19;
    localparam int LAT    = 6;  // drive point (#1 after edge c) to sample point (#1 after edge c+6)

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NCHAN*NSAMP*NBITS-1:0]  data;
    logic [1:0]                    cfg_beam;
    logic [3:0]                    cfg_sel;
    logic [PBITS-1:0]              cfg_dat;
    logic                          cfg_wr;
    logic                          cfg_upd;
    logic [NBEAMS-1:0]             trig;

    int cyc  = 0;
    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int                due;
        logic [NBEAMS-1:0] val;
        string             tag;
    } exp_t;

    exp_t sbq[$];

    prog_beam_trigger #(
        .NCHAN (NCHAN),
        .NBITS (NBITS),
        .NSAMP (NSAMP),
        .NBEAMS(NBEAMS),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .cfg_beam_i  (cfg_beam),
        .cfg_sel_i   (cfg_sel),
        .cfg_dat_i   (cfg_dat),
        .cfg_wr_i    (cfg_wr),
        .cfg_update_i(cfg_upd),
        .trigger_o   (trig)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [NBITS-1:0] v);
        for (int i = 0; i < NCHAN * NSAMP; i++) data[i*NBITS +: NBITS] = v;
    endtask

    task automatic cfg(input logic [1:0] b, input logic [3:0] sel, input logic [PBITS-1:0] dat);
        cfg_beam = b;
        cfg_sel  = sel;
        cfg_dat  = dat;
        cfg_wr   = 1'b1;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic update_and_settle();
        cfg_upd = 1'b1;
        step();
        cfg_upd = 1'b0;
        fill('0);
        repeat (8) step();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        fill('0);
        repeat (2) step();
        nvec++;
        if (trig !== 4'b0000) begin
            nmis++;
            $display("FAIL reset_state: trigger_o=%b expected 0000", trig);
        end
        rst = 1'b0;
        // thresholds come out of reset as all-ones, so even a strong signal never fires
        for (int i = 0; i < 10 + LAT; i++) begin
            if (i < 10) begin
                fill(5'd1);
                sbq.push_back(exp_t'{cyc + LAT, 4'b0000, "reset_thr_allones"});
            end else fill('0);
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
    endtask

    task automatic test_power512();
        exp_t e;
        logic [3:0] ev;
        cfg(2'd0, 4'd8, 19'd511);
        cfg(2'd0, 4'd9, 19'd0);
        update_and_settle();
        for (int pass = 0; pass < 2; pass++) begin
            ev = (pass == 0) ? 4'b0001 : 4'b0000;
            for (int i = 0; i < 12 + LAT; i++) begin
                if (i < 12) begin
                    fill(5'd1);
                    sbq.push_back(exp_t'{cyc + LAT, ev, (pass == 0) ? "pwr512_thr511" : "pwr512_thr512"});
                end else fill('0);
                step();
                while (sbq.size() != 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    nvec++;
                    if (trig !== e.val) begin
                        nmis++;
                        $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                    end
                end
            end
            if (pass == 0) begin
                cfg(2'd0, 4'd8, 19'd512);
                update_and_settle();
            end
        end
    endtask

    task automatic test_holdoff();
        exp_t e;
        cfg(2'd0, 4'd8, 19'd511);
        cfg(2'd0, 4'd9, 19'd3);
        update_and_settle();
        for (int i = 0; i < 16 + LAT; i++) begin
            if (i < 16) begin
                fill(5'd1);
                sbq.push_back(exp_t'{cyc + LAT, (i % 4 == 0) ? 4'b0001 : 4'b0000, "holdoff_h3"});
            end else fill('0);
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
    endtask

    task automatic test_impulse_delay();
        exp_t e;
        int   dl[4] = '{0, 8, 4, 99};
        int   kk[4] = '{0, 1, 1, 3};
        logic [3:0] ev;
        cfg(2'd0, 4'd8, 19'd224);
        cfg(2'd0, 4'd9, 19'd0);
        cfg(2'd1, 4'd8, 19'd224);
        for (int t = 0; t < 4; t++) begin
            cfg(2'd0, 4'd0, 19'(dl[t]));
            update_and_settle();
            // beam1 keeps zero delay and is the reference; beam0 ch0 carries the delay
            for (int i = 0; i < 6 + LAT; i++) begin
                fill('0);
                if (i == 0) data[7*NBITS +: NBITS] = 5'd15;
                if (i < 6) begin
                    ev = {2'b00, (i == 0), (i == kk[t])};
                    sbq.push_back(exp_t'{cyc + LAT, ev, $sformatf("impulse_dly%0d", dl[t])});
                end
                step();
                while (sbq.size() != 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    nvec++;
                    if (trig !== e.val) begin
                        nmis++;
                        $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                    end
                end
            end
        end
    endtask

    task automatic test_negative_full_scale();
        exp_t e;
        cfg(2'd0, 4'd0, 19'd0);
        cfg(2'd0, 4'd8, 19'd131071);
        cfg(2'd1, 4'd8, 19'd131072);
        update_and_settle();
        for (int i = 0; i < 12 + LAT; i++) begin
            if (i < 12) begin
                fill(5'b10000);
                sbq.push_back(exp_t'{cyc + LAT, 4'b0001, "neg16_pwr131072"});
            end else fill('0);
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
    endtask

    task automatic test_update_midstream();
        exp_t e;
        logic [3:0] ev;
        // shadow write at 4, write+update at 10 (write must not reach active), plain update at 20
        for (int i = 0; i < 30 + LAT; i++) begin
            cfg_wr  = 1'b0;
            cfg_upd = 1'b0;
            fill(5'b10000);
            if (i == 4) begin
                cfg_beam = 2'd1; cfg_sel = 4'd8; cfg_dat = 19'd0; cfg_wr = 1'b1;
            end
            if (i == 10) begin
                cfg_beam = 2'd0; cfg_sel = 4'd8; cfg_dat = '1; cfg_wr = 1'b1; cfg_upd = 1'b1;
            end
            if (i == 20) cfg_upd = 1'b1;
            if (i < 30) begin
                if (i < 6)       ev = 4'b0001;
                else if (i < 11) ev = 4'b0000;
                else if (i < 16) ev = 4'b0011;
                else if (i < 21) ev = 4'b0000;
                else             ev = 4'b0010;
                sbq.push_back(exp_t'{cyc + LAT, ev, "update_midstream"});
            end
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
        cfg_wr  = 1'b0;
        cfg_upd = 1'b0;
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        for (int i = 0; i < 24 + LAT; i++) begin
            cfg_wr  = 1'b0;
            cfg_upd = 1'b0;
            rst     = (i == 8 || i == 9);
            fill(5'b10000);
            if (i == 2) begin
                cfg_beam = 2'd2; cfg_sel = 4'd8; cfg_dat = 19'd0; cfg_wr = 1'b1;
            end
            if (i == 16) cfg_upd = 1'b1;
            if (i < 24) sbq.push_back(exp_t'{cyc + LAT, (i < 3) ? 4'b0010 : 4'b0000, "reset_midstream"});
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
        rst     = 1'b0;
        cfg_upd = 1'b0;
        cfg(2'd3, 4'd8, 19'd131071);
        update_and_settle();
        for (int i = 0; i < 8 + LAT; i++) begin
            if (i < 8) begin
                fill(5'b10000);
                sbq.push_back(exp_t'{cyc + LAT, 4'b1000, "reconfig_after_reset"});
            end else fill('0);
            step();
            while (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                nvec++;
                if (trig !== e.val) begin
                    nmis++;
                    $display("FAIL %s: cycle %0d trigger_o=%b expected %b", e.tag, cyc, trig, e.val);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        cfg_beam = '0;
        cfg_sel  = '0;
        cfg_dat  = '0;
        cfg_wr   = 1'b0;
        cfg_upd  = 1'b0;
        fill('0);
        test_reset();
        test_power512();
        test_holdoff();
        test_impulse_delay();
        test_negative_full_scale();
        test_update_midstream();
        test_reset_midstream();
        nvec++;
        if (sbq.size() != 0) begin
            nmis++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
